// File: rtl/vga_fill_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_fill_pkg : shared encodings for the VRAM rectangle-fill engine   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package vga_fill_pkg;

  localparam int DEF_H_CELLS = 40;
  localparam int DEF_V_CELLS = 30;
  localparam int DEF_ADDR_W  = 11;
  localparam int DEF_COLOR_W = 3;

  // 3-bit RGB color codes used by the VGA instruction set
  localparam logic [2:0] COLOR_BLACK   = 3'd0;
  localparam logic [2:0] COLOR_BLUE    = 3'd1;
  localparam logic [2:0] COLOR_GREEN   = 3'd2;
  localparam logic [2:0] COLOR_CYAN    = 3'd3;
  localparam logic [2:0] COLOR_RED     = 3'd4;
  localparam logic [2:0] COLOR_MAGENTA = 3'd5;
  localparam logic [2:0] COLOR_YELLOW  = 3'd6;
  localparam logic [2:0] COLOR_WHITE   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } fill_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_fill_walker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_fill_walker : raster x/y walker producing the current cell addr  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module vga_fill_walker
  import vga_fill_pkg::*;
#(
  parameter int H_CELLS = DEF_H_CELLS,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_advance,
  input  logic [5:0]        i_x0,
  input  logic [5:0]        i_x1,
  input  logic [4:0]        i_y0,
  input  logic [4:0]        i_y1,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  logic [5:0]        r_x;
  logic [4:0]        r_y;
  logic [ADDR_W-1:0] r_row_base;

  // Row base is multiplied once at load; each row wrap only adds H_CELLS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x        <= '0;
      r_y        <= '0;
      r_row_base <= '0;
    end else if (i_load) begin
      r_x        <= i_x0;
      r_y        <= i_y0;
      r_row_base <= ADDR_W'(i_y0) * ADDR_W'(H_CELLS);
    end else if (i_advance) begin
      if (r_x == i_x1) begin
        r_x        <= i_x0;
        r_y        <= r_y + 5'd1;
        r_row_base <= r_row_base + ADDR_W'(H_CELLS);
      end else begin
        r_x <= r_x + 6'd1;
      end
    end
  end

  assign o_addr = r_row_base + ADDR_W'(r_x);
  assign o_last = (r_x == i_x1) && (r_y == i_y1);

endmodule
`default_nettype wire

// File: rtl/vga_fill_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_fill_ctrl : rectangle-fill engine + VRAM write-port arbiter      |
// | Option macro VGA_FILL_VBLANK_EN: engine writes only during blanking  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module vga_fill_ctrl
  import vga_fill_pkg::*;
#(
  parameter int H_CELLS      = DEF_H_CELLS,
  parameter int V_CELLS      = DEF_V_CELLS,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int COLOR_W      = DEF_COLOR_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               iCpuWrEn,
  input  logic [ADDR_W-1:0]  iCpuAddr,
  input  logic [COLOR_W-1:0] iCpuColor,
  output logic               oCpuStall,
  input  logic               iFillStart,
  input  logic [5:0]         iX0,
  input  logic [5:0]         iX1,
  input  logic [4:0]         iY0,
  input  logic [4:0]         iY1,
  input  logic [COLOR_W-1:0] iFillColor,
  output logic               oFillBusy,
  output logic               oFillDone,
  output logic               oFillErr,
  input  logic               iVBlank,
  output logic               oVramWrEn,
  output logic [ADDR_W-1:0]  oVramAddr,
  output logic [COLOR_W-1:0] oVramData
);

  localparam int c_starve_w = $clog2(STARVE_LIMIT + 1);

  fill_state_t        r_state;
  logic [5:0]         r_x0;
  logic [5:0]         r_x1;
  logic [4:0]         r_y0;
  logic [4:0]         r_y1;
  logic [COLOR_W-1:0] r_color;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [c_starve_w-1:0] r_starve;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_addr;
  logic [COLOR_W-1:0] r_data;

  logic [ADDR_W-1:0]  w_walk_addr;
  logic               w_walk_last;
  logic               w_eng_req;
  logic               w_starved;
  logic               w_eng_grant;
  logic               w_cpu_grant;
  logic               w_bad_cmd;

`ifdef VGA_FILL_VBLANK_EN
  // Outside blanking the engine neither requests nor accrues starvation
  assign w_eng_req = (r_state == ST_RUN) && iVBlank;
`else
  logic w_unused_vblank;
  assign w_unused_vblank = iVBlank;
  assign w_eng_req       = (r_state == ST_RUN);
`endif

  assign w_starved   = (r_starve == c_starve_w'(STARVE_LIMIT));
  assign w_eng_grant = w_eng_req && (!iCpuWrEn || w_starved);
  assign w_cpu_grant = iCpuWrEn && !w_eng_grant;
  assign oCpuStall   = iCpuWrEn && w_eng_grant;

  assign w_bad_cmd = (iX0 > iX1) || (iY0 > iY1) ||
                     (32'(iX1) >= H_CELLS) || (32'(iY1) >= V_CELLS);

  vga_fill_walker #(
    .H_CELLS (H_CELLS),
    .ADDR_W  (ADDR_W)
  ) u_walker (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (r_state == ST_SETUP),
    .i_advance (w_eng_grant),
    .i_x0      (r_x0),
    .i_x1      (r_x1),
    .i_y0      (r_y0),
    .i_y1      (r_y1),
    .o_addr    (w_walk_addr),
    .o_last    (w_walk_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_x0    <= '0;
      r_x1    <= '0;
      r_y0    <= '0;
      r_y1    <= '0;
      r_color <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (iFillStart) begin
            r_x0    <= iX0;
            r_x1    <= iX1;
            r_y0    <= iY0;
            r_y1    <= iY1;
            r_color <= iFillColor;
            if (w_bad_cmd) begin
              r_state <= ST_DONE;
              r_err   <= 1'b1;
            end else begin
              r_state <= ST_SETUP;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_SETUP: r_state <= ST_RUN;
        ST_RUN: begin
          if (w_eng_grant && w_walk_last) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if ((r_state != ST_RUN) || w_eng_grant) begin
      r_starve <= '0;
    end else if (w_eng_req) begin
      r_starve <= r_starve + c_starve_w'(1);
    end
  end

  // Address/data hold their last value on idle cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_wr_en <= w_eng_grant || w_cpu_grant;
      if (w_eng_grant) begin
        r_addr <= w_walk_addr;
        r_data <= r_color;
      end else if (w_cpu_grant) begin
        r_addr <= iCpuAddr;
        r_data <= iCpuColor;
      end
    end
  end

  assign oFillBusy = r_busy;
  assign oFillDone = r_done;
  assign oFillErr  = r_err;
  assign oVramWrEn = r_wr_en;
  assign oVramAddr = r_addr;
  assign oVramData = r_data;

endmodule
`default_nettype wire

// File: tb/tb_vga_fill_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vga_fill_ctrl : scoreboard bench for the VRAM fill engine/arbiter |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_vga_fill_ctrl;
  import vga_fill_pkg::*;

  localparam int AW = 11;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          iCpuWrEn = 1'b0;
  logic [AW-1:0] iCpuAddr = '0;
  logic [CW-1:0] iCpuColor = '0;
  logic          oCpuStall;
  logic          iFillStart = 1'b0;
  logic [5:0]    iX0 = '0;
  logic [5:0]    iX1 = '0;
  logic [4:0]    iY0 = '0;
  logic [4:0]    iY1 = '0;
  logic [CW-1:0] iFillColor = '0;
  logic          oFillBusy;
  logic          oFillDone;
  logic          oFillErr;
  logic          iVBlank = 1'b1;
  logic          oVramWrEn;
  logic [AW-1:0] oVramAddr;
  logic [CW-1:0] oVramData;

  vga_fill_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .iCpuWrEn   (iCpuWrEn),
    .iCpuAddr   (iCpuAddr),
    .iCpuColor  (iCpuColor),
    .oCpuStall  (oCpuStall),
    .iFillStart (iFillStart),
    .iX0        (iX0),
    .iX1        (iX1),
    .iY0        (iY0),
    .iY1        (iY1),
    .iFillColor (iFillColor),
    .oFillBusy  (oFillBusy),
    .oFillDone  (oFillDone),
    .oFillErr   (oFillErr),
    .iVBlank    (iVBlank),
    .oVramWrEn  (oVramWrEn),
    .oVramAddr  (oVramAddr),
    .oVramData  (oVramData)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int stall_cnt = 0;
  int done_cyc = 0;
  int err_cyc = 0;
  int start_cyc = 0;
  logic [AW+CW-1:0] exp_q[$];
  logic [AW+CW-1:0] mon_w;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_wr(input int addr, input int color);
    exp_q.push_back({AW'(addr), CW'(color)});
  endtask

  task automatic push_rect(input int x0, input int x1, input int y0, input int y1,
                           input int color);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        push_wr(y * 40 + x, color);
  endtask

  // Called just after a rising edge; leaves the bench one cycle later
  task automatic start_fill(input int x0, input int x1, input int y0, input int y1,
                            input int color);
    iX0        = 6'(x0);
    iX1        = 6'(x1);
    iY0        = 5'(y0);
    iY1        = 5'(y1);
    iFillColor = CW'(color);
    iFillStart = 1'b1;
    start_cyc  = cyc;
    @(posedge clk);
    #1;
    iFillStart = 1'b0;
  endtask

  task automatic wait_evt(input int limit);
    int base = done_cnt + err_cnt;
    bit got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge clk);
      #1;
      got = ((done_cnt + err_cnt) != base);
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_timeout: no done/err pulse within %0d cycles", limit);
    end
  endtask

  task automatic mon_step();
    if (oVramWrEn) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %0d, expected no write",
                 int'(oVramAddr), int'(oVramData));
      end else begin
        mon_w = exp_q.pop_front();
        check("vram_addr", int'(oVramAddr), int'(mon_w[AW+CW-1:CW]));
        check("vram_data", int'(oVramData), int'(mon_w[CW-1:0]));
      end
    end
    if (oFillDone) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (oFillErr) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (oCpuStall) stall_cnt++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int d0;
    int e0;

    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", int'(oVramWrEn), 0);
    check("rst_addr", int'(oVramAddr), 0);
    check("rst_data", int'(oVramData), 0);
    check("rst_busy", int'(oFillBusy), 0);
    check("rst_done", int'(oFillDone), 0);
    check("rst_err", int'(oFillErr), 0);
    check("rst_stall", int'(oCpuStall), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full-width 18-row fill, uncontended
    w0 = wr_cnt;
    push_rect(0, 39, 0, 17, int'(COLOR_CYAN));
    @(posedge clk);
    #1;
    start_fill(0, 39, 0, 17, int'(COLOR_CYAN));
    check("s1_busy", int'(oFillBusy), 1);
    wait_evt(800);
    check("s1_done_latency", done_cyc - start_cyc, 722);
    check("s1_writes", wr_cnt - w0, 720);
    check("s1_queue_left", exp_q.size(), 0);
    check("s1_busy_after", int'(oFillBusy), 0);

    // Small rectangle spanning two rows
    w0 = wr_cnt;
    push_rect(32, 35, 4, 5, int'(COLOR_YELLOW));
    @(posedge clk);
    #1;
    start_fill(32, 35, 4, 5, int'(COLOR_YELLOW));
    wait_evt(40);
    check("s2_done_latency", done_cyc - start_cyc, 10);
    check("s2_writes", wr_cnt - w0, 8);
    check("s2_queue_left", exp_q.size(), 0);

    // Same fill against a CPU that requests every cycle
    w0 = wr_cnt;
    stall_cnt = 0;
    for (int c = 0; c < 42; c++) begin
      if (c >= 6 && ((c - 6) % 5) == 0) begin
        if (((c - 6) / 5) < 4) push_wr(192 + (c - 6) / 5, int'(COLOR_YELLOW));
        else push_wr(232 + (c - 6) / 5 - 4, int'(COLOR_YELLOW));
      end else begin
        push_wr(1000, int'(COLOR_BLUE));
      end
    end
    @(posedge clk);
    #1;
    iCpuWrEn  = 1'b1;
    iCpuAddr  = AW'(1000);
    iCpuColor = COLOR_BLUE;
    start_fill(32, 35, 4, 5, int'(COLOR_YELLOW));
    repeat (41) begin
      @(posedge clk);
      #1;
    end
    iCpuWrEn = 1'b0;
    wait_evt(20);
    check("s3_done_latency", done_cyc - start_cyc, 42);
    check("s3_stalls", stall_cnt, 8);
    check("s3_writes", wr_cnt - w0, 42);
    check("s3_queue_left", exp_q.size(), 0);

    // Reversed column bounds must be rejected without writes
    w0 = wr_cnt;
    d0 = done_cnt;
    e0 = err_cnt;
    @(posedge clk);
    #1;
    start_fill(10, 5, 0, 0, int'(COLOR_GREEN));
    wait_evt(10);
    check("s4_err_latency", err_cyc - start_cyc, 1);
    check("s4_err_count", err_cnt - e0, 1);
    check("s4_no_done", done_cnt - d0, 0);
    repeat (3) @(negedge clk);
    #1;
    check("s4_no_writes", wr_cnt - w0, 0);
    check("s4_busy", int'(oFillBusy), 0);

    // Reset after three writes abandons the fill silently
    w0 = wr_cnt;
    d0 = done_cnt;
    e0 = err_cnt;
    push_rect(0, 2, 0, 0, int'(COLOR_MAGENTA));
    @(posedge clk);
    #1;
    start_fill(0, 39, 0, 0, int'(COLOR_MAGENTA));
    for (int i = 0; i < 20 && (wr_cnt - w0) < 3; i++) begin
      @(negedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check("s5_wr_en", int'(oVramWrEn), 0);
    check("s5_addr", int'(oVramAddr), 0);
    check("s5_data", int'(oVramData), 0);
    check("s5_busy", int'(oFillBusy), 0);
    check("s5_done", int'(oFillDone), 0);
    check("s5_err", int'(oFillErr), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("s5_writes", wr_cnt - w0, 3);
    check("s5_no_done", done_cnt - d0, 0);
    check("s5_no_err", err_cnt - e0, 0);
    check("s5_queue_left", exp_q.size(), 0);

    w0 = wr_cnt;
    push_rect(2, 3, 1, 1, int'(COLOR_GREEN));
    @(posedge clk);
    #1;
    start_fill(2, 3, 1, 1, int'(COLOR_GREEN));
    wait_evt(20);
    check("s5_refill_latency", done_cyc - start_cyc, 4);
    check("s5_refill_writes", wr_cnt - w0, 2);

`ifdef VGA_FILL_VBLANK_EN
    // Engine must pause outside blanking and resume at the held position
    w0 = wr_cnt;
    iVBlank = 1'b0;
    push_rect(0, 3, 0, 0, int'(COLOR_WHITE));
    @(posedge clk);
    #1;
    start_fill(0, 3, 0, 0, int'(COLOR_WHITE));
    repeat (10) @(negedge clk);
    #1;
    check("s6_paused_writes", wr_cnt - w0, 0);
    check("s6_paused_busy", int'(oFillBusy), 1);
    iVBlank = 1'b1;
    wait_evt(20);
    check("s6_writes", wr_cnt - w0, 4);
    check("s6_queue_left", exp_q.size(), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_fill_ctrl.md
Name: vga_fill_ctrl

Overview:
- Hardware rectangle-fill engine and write-port arbiter for the 40x30 cell video RAM.
- Takes over the CPU's nested fill loops (sky, grass, checkerboard background): the CPU issues one fill command; the block walks the rectangle and writes one cell per cycle.
- Shares the single VRAM write port between single-cell CPU VGA-instruction writes and the fill engine, with starvation protection for the engine.

Parameters:
- H_CELLS, 40, cells per row; address = y*H_CELLS + x
- V_CELLS, 30, rows
- ADDR_W, 11, VRAM address width; must satisfy H_CELLS*V_CELLS <= 2^ADDR_W
- COLOR_W, 3, color code width, same encoding as the COLOR_* definitions
- STARVE_LIMIT, 4, consecutive lost arbitration cycles before the fill engine is forced a slot

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- iCpuWrEn  in  1  CPU VGA-instruction write request
- iCpuAddr  in  ADDR_W  CPU write cell address
- iCpuColor  in  COLOR_W  CPU write color
- oCpuStall  out  1  CPU write not accepted this cycle; CPU holds its request
- iFillStart  in  1  one-cycle fill command strobe
- iX0, iX1  in  6  inclusive column bounds
- iY0, iY1  in  5  inclusive row bounds
- iFillColor  in  COLOR_W  fill color
- oFillBusy  out  1  engine is in SETUP or RUN
- oFillDone  out  1  one-cycle pulse at completion
- oFillErr  out  1  one-cycle pulse when the command is rejected
- iVBlank  in  1  vertical blanking flag; used only with the optional feature
- oVramWrEn  out  1  registered VRAM write enable
- oVramAddr  out  ADDR_W  registered VRAM write address
- oVramData  out  COLOR_W  registered VRAM write data

Behaviour:
- Reset: all outputs are 0, FSM goes to IDLE, starvation counter is 0. Reset asserted mid-fill abandons the fill; no done or error pulse is produced.
- FSM states:
  - IDLE:
    - On iFillStart, latch bounds and color.
    - If x0>x1, y0>y1, x1>=H_CELLS or y1>=V_CELLS, go to DONE with oFillErr (no writes).
    - Otherwise go to SETUP.
  - SETUP (1 cycle): rowBase = y0*H_CELLS; x = x0; y = y0.
  - RUN:
    - Each granted cycle writes rowBase+x with the fill color.
    - If x==x1: x = x0, y++, rowBase += H_CELLS (incremental, no multiply).
    - If x==x1 and y==y1: go to DONE after that write.
    - Otherwise x++.
  - DONE (1 cycle): pulse oFillDone (or oFillErr), then go to IDLE.
- iFillStart while oFillBusy is ignored. iFillStart in the DONE cycle is also ignored.
- Write count is exactly (x1-x0+1)*(y1-y0+1); each cell is written once, in raster order.
- Arbitration, per cycle:
  - CPU request wins unless the engine is in RUN and starveCnt==STARVE_LIMIT.
  - The engine wins when in RUN and either there is no CPU request or the starvation limit is reached.
  - oCpuStall = iCpuWrEn & engine wins (combinational).
  - starveCnt increments when the engine is in RUN and loses; it clears on an engine grant or outside RUN.
- Latency:
  - A granted request appears on oVram* the following cycle.
  - iFillStart at cycle 0 gives SETUP at cycle 1 and the first write request at cycle 2, visible on oVram* at cycle 3 if uncontended.
  - oFillDone is asserted in the cycle after the last engine grant.
- oVramWrEn is 0 in any cycle following a cycle with no grant; oVramAddr/oVramData hold their last value.

Optional Feature:
- Macro: VGA_FILL_VBLANK_EN.
- When defined: the engine may only be granted while iVBlank=1.
  - Outside blanking, RUN pauses with position held.
  - The starvation counter does not advance.
  - CPU writes are unaffected.
- When undefined: iVBlank is ignored and the engine is granted whenever arbitration allows.

Decomposition:
- Package vga_fill_pkg holds:
  - state encoding (IDLE, SETUP, RUN, DONE)
  - default H_CELLS/V_CELLS/ADDR_W
  - COLOR_* codes matching the existing definitions
- Sub-module vga_fill_walker holds the x/y/rowBase raster walker: inputs are load/advance; outputs are addr and last.
- The top level holds the FSM, the arbiter and the output registers.

Test Plan:
- Fill x0=0,x1=39,y0=0,y1=17 in CYAN, no CPU traffic -> 720 consecutive writes, addresses 0..719, oFillDone at cycle 722 after start.
- Fill x0=32,x1=35,y0=4,y1=5 in YELLOW -> 8 writes at 192..195 and 232..235, then a done pulse.
- Continuous iCpuWrEn during the fill from the previous scenario -> oCpuStall high once every 5 cycles, engine gets 1 grant per 5 cycles, all 8 writes still complete.
- Fill with x0=10,x1=5 -> oFillErr pulse 1 cycle after start, no oVramWrEn, engine returns to IDLE.
- Reset deasserted-to-asserted after 3 fill writes -> all outputs 0 next cycle, no done pulse; a new fill then runs normally.
- With VGA_FILL_VBLANK_EN, iVBlank=0 then 1 -> no engine writes while low; writes resume at the held position when high.
